// File: rtl/pipe_ctrl_pkg.sv
// Shared defines for the pipeline controller: stall codes,
// exception codes and the request bundle decoded into stalls.
package pipe_ctrl_pkg;

   localparam logic Stop   = 1'b1;
   localparam logic NoStop = 1'b0;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   localparam logic [31:0] EXC_NONE = 32'h0000_0000;
   localparam logic [31:0] EXC_ERET = 32'h0000_000e;

   localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;

   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_IF   = 6'b000011;
   localparam logic [5:0] STALL_ID   = 6'b000111;
   localparam logic [5:0] STALL_EX   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   typedef struct packed {
      logic mem;
      logic ex;
      logic id;
      logic fetch;
   } stallreq_t;

   // The latest stage asking wins: it must hold everything behind it.
   function automatic logic [5:0] stall_enc(input stallreq_t r);
      logic [5:0] s;
      s = STALL_NONE;
      priority case (1'b1)
         r.mem:   s = STALL_MEM;
         r.ex:    s = STALL_EX;
         r.id:    s = STALL_ID;
         r.fetch: s = STALL_IF;
         default: s = STALL_NONE;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/pipe_ctrl_watchdog.sv
// Counts consecutive busy cycles, saturating at LIMIT, and raises
// a sticky error flag on the edge the count reaches LIMIT.
module stall_watchdog
   import pipe_ctrl_pkg::*;
#(
   parameter int LIMIT = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic busy,
   output logic err
);

   localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = '0;
      if (busy) begin
         if (cnt_q == LIM)
            cnt_d = cnt_q;
         else
            cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err   <= NoStop;
      end else begin
         cnt_q <= cnt_d;
         if (busy && cnt_d == LIM)
            err <= Stop;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall decode, exception flush with a
// one-cycle hold, stall-cycle counter and stall watchdog.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
   parameter int          WDT_LIMIT  = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_if,
   input  logic        stallreq_id,
   input  logic        stallreq_ex,
   input  logic        stallreq_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic [31:0] stall_cycles,
   output logic        wdt_err
);

   state_t    state_q;
   state_t    state_d;
   stallreq_t req;

   assign req = '{
      mem:   stallreq_mem,
      ex:    stallreq_ex,
      id:    stallreq_id,
      fetch: stallreq_if
   };

   always_comb begin
      state_d = state_q;
      stall   = STALL_NONE;
      flush   = NoStop;
      new_pc  = ZeroWord;
      if (!rst) begin
         unique case (state_q)
            IDLE: begin
               if (excepttype_i != EXC_NONE) begin
                  flush   = Stop;
                  state_d = HOLD;
                  if (excepttype_i == EXC_ERET)
                     new_pc = cp0_epc_i;
                  else
                     new_pc = EXC_VECTOR;
               end else begin
                  stall = stall_enc(req);
               end
            end
            // Flushed instructions drain; nothing is accepted here.
            HOLD: state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst)
         stall_cycles <= ZeroWord;
      else if (stall[0])
         stall_cycles <= stall_cycles + 32'd1;
   end

   stall_watchdog #(
      .LIMIT (WDT_LIMIT)
   ) u_wdt (
      .clk  (clk),
      .rst  (rst),
      .busy (stall != STALL_NONE),
      .err  (wdt_err)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for the decode and
// exception path, plus hand sequences for counters and reset.
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic [31:0] excepttype_i;
   logic [31:0] cp0_epc_i;
   logic [5:0]  stall;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] stall_cycles;
   logic        wdt_err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   pipe_ctrl #(
      .EXC_VECTOR (32'h0000_0020),
      .WDT_LIMIT  (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_if  (stallreq_if),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .stallreq_mem (stallreq_mem),
      .excepttype_i (excepttype_i),
      .cp0_epc_i    (cp0_epc_i),
      .stall        (stall),
      .flush        (flush),
      .new_pc       (new_pc),
      .stall_cycles (stall_cycles),
      .wdt_err      (wdt_err)
   );

   typedef struct {
      logic [3:0]  req;
      logic [31:0] exc;
      logic [31:0] epc;
      logic [5:0]  e_stall;
      logic        e_flush;
      logic [31:0] e_pc;
   } vec_t;

   vec_t vt[16];

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [3:0] r,
                        input logic [31:0] e,
                        input logic [31:0] p);
      {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = r;
      excepttype_i = e;
      cp0_epc_i    = p;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive(4'b0000, 32'h0, 32'h0);
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      // req bits: {mem, ex, id, if}
      vt[0]  = '{4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0};
      vt[1]  = '{4'b0001, 32'h0, 32'h0, 6'b000011, 1'b0, 32'h0};
      vt[2]  = '{4'b0010, 32'h0, 32'h0, 6'b000111, 1'b0, 32'h0};
      vt[3]  = '{4'b0100, 32'h0, 32'h0, 6'b001111, 1'b0, 32'h0};
      vt[4]  = '{4'b1000, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0};
      vt[5]  = '{4'b1001, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0};
      vt[6]  = '{4'b0110, 32'h0, 32'h0, 6'b001111, 1'b0, 32'h0};
      vt[7]  = '{4'b1111, 32'h0, 32'h0, 6'b011111, 1'b0, 32'h0};
      vt[8]  = '{4'b0010, 32'h8, 32'h0, 6'b000000, 1'b1, 32'h20};
      vt[9]  = '{4'b1000, 32'h8, 32'h0, 6'b000000, 1'b0, 32'h0};
      vt[10] = '{4'b0000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0};
      vt[11] = '{4'b0000, 32'he, 32'h1234, 6'b000000, 1'b1, 32'h1234};
      vt[12] = '{4'b0001, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0};
      vt[13] = '{4'b0001, 32'h0, 32'h0, 6'b000011, 1'b0, 32'h0};
      vt[14] = '{4'b0000, 32'h5, 32'h1234, 6'b000000, 1'b1, 32'h20};
      vt[15] = '{4'b1000, 32'h0, 32'h0, 6'b000000, 1'b0, 32'h0};

      rst = 1'b1;
      drive(4'b1111, 32'h8, 32'h1234);
      @(negedge clk);
      #1;
      check("rst_stall", 32'(stall), 32'h0);
      check("rst_flush", 32'(flush), 32'h0);
      check("rst_new_pc", new_pc, 32'h0);
      step();
      rst = 1'b0;
      drive(4'b0000, 32'h0, 32'h0);
      #1;
      check("rst_cycles", stall_cycles, 32'h0);
      check("rst_wdt", 32'(wdt_err), 32'h0);

      for (int i = 0; i < 16; i++) begin
         drive(vt[i].req, vt[i].exc, vt[i].epc);
         #1;
         check($sformatf("vec%0d_stall", i),
               32'(stall), 32'(vt[i].e_stall));
         check($sformatf("vec%0d_flush", i),
               32'(flush), 32'(vt[i].e_flush));
         check($sformatf("vec%0d_pc", i), new_pc, vt[i].e_pc);
         step();
      end

      // ex stall alone for three cycles
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(4'b0100, 32'h0, 32'h0);
         #1;
         check($sformatf("ex3_stall%0d", i), 32'(stall), 32'h0f);
         step();
      end
      drive(4'b0000, 32'h0, 32'h0);
      #1;
      check("ex3_cycles", stall_cycles, 32'd3);
      check("ex3_no_wdt", 32'(wdt_err), 32'h0);

      // exception with stall request counts as non-stall
      drive(4'b0010, 32'h8, 32'h0);
      step();
      drive(4'b0000, 32'h0, 32'h0);
      #1;
      check("exc_no_count", stall_cycles, 32'd3);

      // watchdog trips on the 4th consecutive stall edge
      do_reset();
      drive(4'b1000, 32'h0, 32'h0);
      step();
      step();
      step();
      #1;
      check("wdt_edge3", 32'(wdt_err), 32'h0);
      step();
      #1;
      check("wdt_edge4", 32'(wdt_err), 32'h1);
      drive(4'b0000, 32'h0, 32'h0);
      step();
      step();
      #1;
      check("wdt_sticky", 32'(wdt_err), 32'h1);
      do_reset();
      #1;
      check("wdt_rst", 32'(wdt_err), 32'h0);

      // a break in stalls restarts the watchdog count
      drive(4'b0001, 32'h0, 32'h0);
      step();
      step();
      step();
      drive(4'b0000, 32'h0, 32'h0);
      step();
      drive(4'b0001, 32'h0, 32'h0);
      step();
      step();
      step();
      #1;
      check("wdt_restart", 32'(wdt_err), 32'h0);

      // stall_cycles wraps
      do_reset();
      force dut.stall_cycles = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cycles;
      #1;
      check("wrap_pre", stall_cycles, 32'hFFFF_FFFF);
      drive(4'b0001, 32'h0, 32'h0);
      step();
      drive(4'b0000, 32'h0, 32'h0);
      #1;
      check("wrap_zero", stall_cycles, 32'h0);

      // reset while in HOLD
      drive(4'b0000, 32'h8, 32'h0);
      step();
      rst = 1'b1;
      drive(4'b1111, 32'h8, 32'h0);
      #1;
      check("hold_rst_stall", 32'(stall), 32'h0);
      check("hold_rst_flush", 32'(flush), 32'h0);
      check("hold_rst_pc", new_pc, 32'h0);
      step();
      rst = 1'b0;
      drive(4'b0010, 32'h0, 32'h0);
      #1;
      check("post_rst_stall", 32'(stall), 32'h07);
      check("post_rst_flush", 32'(flush), 32'h0);
      drive(4'b0000, 32'h8, 32'h0);
      #1;
      check("post_rst_idle", 32'(flush), 32'h1);
      check("post_rst_pc", new_pc, 32'h20);
      step();
      drive(4'b0000, 32'h0, 32'h0);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameters SHALL be: EXC_VECTOR, default 32'h00000020, exception handler entry PC; WDT_LIMIT, default 1023, consecutive-stall cycles that trip the watchdog.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stallreq_if, stallreq_id, stallreq_ex, stallreq_mem  input  1 each  stall requests from IF, ID, EX, MEM.
REQ-005 excepttype_i  input  32  exception code from MEM; zero means none; 32'h0000000e means eret.
REQ-006 cp0_epc_i  input  32  current EPC value from CP0.
REQ-007 stall  output  6  per-stage hold: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB.
REQ-008 flush  output  1  clears all pipeline registers at the next edge.
REQ-009 new_pc  output  32  PC target, valid only while flush=1.
REQ-010 stall_cycles  output  32  count of cycles with stall[0]=1.
REQ-011 wdt_err  output  1  sticky watchdog trip flag.

Function
REQ-012 stall, flush and new_pc SHALL be combinational from current state and inputs, so pipeline registers see them at the same edge.
REQ-013 Stall encoding SHALL use latest-stage priority: mem -> 6'b011111; else ex -> 6'b001111; else id -> 6'b000111; else if -> 6'b000011; else 6'b000000.
REQ-014 FSM SHALL have states IDLE and HOLD.
REQ-015 In IDLE with excepttype_i != 0: flush=1, stall=6'b000000 regardless of stall requests, next state HOLD.
REQ-016 new_pc SHALL equal cp0_epc_i when excepttype_i = 32'h0000000e, EXC_VECTOR for any other nonzero code, and 32'h0 when flush=0.
REQ-017 HOLD SHALL last exactly one cycle: flush=0, stall=6'b000000, excepttype_i and stall requests ignored, then IDLE.
REQ-018 In IDLE with excepttype_i = 0, flush=0 and stall SHALL follow REQ-013.
REQ-019 stall_cycles SHALL increment by 1 on each edge where stall[0]=1 and wrap from 32'hFFFFFFFF to 0.
REQ-020 The watchdog counter SHALL increment on each edge where stall != 0, clear on any edge where stall = 0, and saturate at WDT_LIMIT.
REQ-021 wdt_err SHALL set on the edge where the watchdog counter reaches WDT_LIMIT and remain 1 until rst.
REQ-022 Simultaneous exception and stall request: the exception SHALL win per REQ-015, and that cycle SHALL count as a non-stall cycle.

Reset
REQ-023 While rst=1: stall=0, flush=0, new_pc=0; at the edge, state=IDLE, stall_cycles=0, watchdog counter=0, wdt_err=0.
REQ-024 rst asserted in HOLD or mid-stall SHALL abort the operation with no residual flush or stall after reset.

Structure
REQ-025 Stop/NoStop, ZeroWord, exception codes (eret 32'h0000000e) and the EXC_VECTOR default SHALL live in the shared defines package.
REQ-026 The watchdog counter and sticky flag SHALL be one sub-module, stall_watchdog, with ports clk, rst, busy and err, and parameter LIMIT.

Verification
REQ-027 stallreq_ex=1 alone for 3 cycles -> stall=6'b001111 each cycle, stall_cycles=3 afterwards.
REQ-028 stallreq_if=1 and stallreq_mem=1 together -> stall=6'b011111.
REQ-029 excepttype_i=32'h00000008 with stallreq_id=1 -> that cycle flush=1, stall=0, new_pc=32'h00000020; next cycle HOLD with flush=0 even if excepttype_i is still nonzero; the cycle after that is IDLE.
REQ-030 excepttype_i=32'h0000000e, cp0_epc_i=32'h00001234 -> flush=1, new_pc=32'h00001234.
REQ-031 WDT_LIMIT=4, stallreq_mem held 4 cycles -> wdt_err=1 after the 4th edge; it stays 1 after the request drops; rst clears it.
REQ-032 Preload stall_cycles to 32'hFFFFFFFF via force, then one stall cycle -> 0; rst asserted during HOLD -> state IDLE, outputs 0.
